booth_arbiter: RTL and testbench
================================

// Module: booth_arbiter
// PURPOSE
//   Shares one vote-tally datapath (enable/admin_mode/vote_A/B/C inputs) among N_BOOTH voting booths.
//   Runs the poll session (IDLE/OPEN/CLOSING/CLOSED) and arbitrates booth requests round-robin.
//   Emits clean single-cycle one-hot vote pulses to the tally and answers each booth with ack/nack.
//   Per-booth cooldown blocks rapid re-voting.
// PARAMETERS
//   N_BOOTH   4   number of booths, 2..8
//   COOLDOWN  4   cycles after a booth's grant before it may be granted again, 1..15
// PORTS
//   clk           in   1          system clock, rising edge
//   rst_n         in   1          asynchronous, active-low reset
//   open_poll     in   1          admin pulse: open voting
//   close_poll    in   1          admin pulse: close voting
//   booth_req     in   N_BOOTH    per-booth request, held until ack/nack
//   booth_choice  in   2*N_BOOTH  booth i choice at [2i+1:2i]: 01=A 10=B 11=C 00=invalid
//   booth_ack     out  N_BOOTH    one-cycle pulse: vote accepted
//   booth_nack    out  N_BOOTH    one-cycle pulse: vote rejected
//   tally_enable  out  1          drives tally enable
//   tally_admin   out  1          drives tally admin_mode
//   vote_A        out  1          one-cycle vote pulses to tally; at most one high per cycle
//   vote_B        out  1          (same)
//   vote_C        out  1          (same)
//   votes_total   out  16         accepted-vote count, saturating
//   poll_state    out  2          00 IDLE, 01 OPEN, 10 CLOSING, 11 CLOSED
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, RR pointer 0, cooldown counters 0, in-flight vote dropped.
//     Reset is asynchronous and applies immediately, mid-operation included.
//   State machine:
//     IDLE->OPEN on open_poll. close_poll is ignored in IDLE. Requests are held, not served, in IDLE.
//     OPEN->CLOSING on close_poll. close_poll wins if open_poll is high in the same cycle.
//     CLOSING->CLOSED after exactly 1 cycle. Any in-flight vote completes.
//     CLOSED is terminal until rst_n. open_poll is ignored in CLOSED.
//   tally_enable = 1 in OPEN and CLOSING. tally_admin = 1 in CLOSED only. Both are registered.
//   Arbitration (OPEN only): two-cycle slot.
//     Grant cycle T: choose eligible booth (req=1, cooldown=0).
//       Search starts at the booth after the last granted one. Pointer starts at booth 0 after reset.
//     Sample that booth's choice at T.
//     T+1, valid choice: ack pulse to the booth; exactly one of vote_A/B/C pulses; votes_total += 1, holds at 0xFFFF.
//     T+1, choice 00: nack pulse only, no vote pulse, no count change.
//     No new grant at T+1, so vote pulses are always separated by >=1 low cycle.
//     The granted booth's cooldown loads COOLDOWN at T+1 and decrements to 0 each cycle.
//     The pointer advances only on grant.
//   Booth must drop req the cycle after ack/nack. Req still high on the 2nd cycle after ack/nack = new request.
//   Choice changes while req is high are undefined. Only the value at the grant cycle counts.
//   CLOSING entry: every booth with req=1 and not granted in flight gets a nack one cycle later.
//   CLOSED: nack[i] pulses the cycle after req[i] is high, provided nack[i] was not high the previous cycle.
//   ack and nack are never high together for one booth. At most one ack per cycle across booths.
// TESTING
//   1 Reset, open_poll, booth0 req choice=01 -> grant, ack[0]+vote_A pulse 2 cycles after req; votes_total=1.
//   2 Booths 0..3 req together, choices 01,10,11,01 -> acks in order 0,1,2,3 on every 2nd cycle;
//     vote pulses A,B,C,A; votes_total=4.
//   3 Booth1 re-requests immediately after ack -> not granted for 4 cycles, then acked.
//     Booth2 pending meanwhile is served first.
//   4 Booth0 choice=00 -> nack[0], no vote pulse, votes_total unchanged.
//     Booth0 with choice=11 (A+B style multi-press encoded invalid) is accepted as C only if encoding is 11.
//   5 close_poll while booths 2,3 pending and booth1 in flight -> booth1 ack+vote completes;
//     nack[2], nack[3]; poll_state 10 then 11; tally_admin=1.
//   6 rst_n low mid-grant -> no vote pulse, all outputs 0 immediately; open_poll+close_poll same cycle in OPEN -> CLOSING.

Source files
------------

// File: rtl/booth_arbiter.sv
// booth_arbiter: shares one vote-tally datapath among N_BOOTH voting booths.
// Runs the poll session (IDLE -> OPEN -> CLOSING -> CLOSED), arbitrates booth
// requests round-robin in two-cycle slots, and answers each booth with ack/nack.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   open_poll           admin pulse: open voting (honoured in IDLE only)
//   close_poll          admin pulse: close voting (honoured in OPEN only)
//   booth_req           per-booth request, held until ack/nack
//   booth_choice        booth i choice at [2i+1:2i]: 01=A 10=B 11=C 00=invalid
//   booth_ack/nack      one-cycle per-booth accept/reject pulses
//   tally_enable        high in OPEN and CLOSING
//   tally_admin         high in CLOSED
//   vote_A/B/C          one-cycle one-hot vote pulses to the tally
//   votes_total         saturating count of accepted votes
//   poll_state          00 IDLE, 01 OPEN, 10 CLOSING, 11 CLOSED
module booth_arbiter #(
    parameter int unsigned N_BOOTH  = 4,
    parameter int unsigned COOLDOWN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   open_poll,
    input  logic                   close_poll,
    input  logic [N_BOOTH-1:0]     booth_req,
    input  logic [2*N_BOOTH-1:0]   booth_choice,
    output logic [N_BOOTH-1:0]     booth_ack,
    output logic [N_BOOTH-1:0]     booth_nack,
    output logic                   tally_enable,
    output logic                   tally_admin,
    output logic                   vote_A,
    output logic                   vote_B,
    output logic                   vote_C,
    output logic [15:0]            votes_total,
    output logic [1:0]             poll_state
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_OPEN    = 2'b01;
    localparam logic [1:0] ST_CLOSING = 2'b10;
    localparam logic [1:0] ST_CLOSED  = 2'b11;

    localparam int unsigned IdxW   = (N_BOOTH > 1) ? $clog2(N_BOOTH) : 1;
    localparam logic [3:0]  CdLoad = 4'(COOLDOWN);

    logic [1:0]          state_q, state_d;
    logic                tally_enable_q, tally_admin_q;
    logic [IdxW-1:0]     start_q, start_d;      // first booth examined by the next search
    logic                busy_q;                // a grant was made last cycle
    logic [N_BOOTH-1:0]  ack_q, ack_d;
    logic [N_BOOTH-1:0]  nack_q, nack_d;
    logic                vote_a_q, vote_a_d;
    logic                vote_b_q, vote_b_d;
    logic                vote_c_q, vote_c_d;
    logic [15:0]         total_q, total_d;
    logic [3:0]          cd_q [N_BOOTH];
    logic [3:0]          cd_d [N_BOOTH];

    logic [N_BOOTH-1:0]  eligible;
    logic                found;
    logic [IdxW-1:0]     gnt_idx;
    logic                grant;
    logic [1:0]          gnt_choice;
    int unsigned         scan_idx;

    // Session state machine
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (open_poll)  state_d = ST_OPEN;
            ST_OPEN:    if (close_poll) state_d = ST_CLOSING;
            ST_CLOSING: state_d = ST_CLOSED;
            ST_CLOSED:  state_d = ST_CLOSED;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < N_BOOTH; i++) begin
            eligible[i] = booth_req[i] && (cd_q[i] == 4'd0);
        end
    end

    // Round-robin search starting at start_q, wrapping at N_BOOTH
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        scan_idx = 0;
        for (int unsigned k = 0; k < N_BOOTH; k++) begin
            scan_idx = 32'(start_q) + k;
            if (scan_idx >= N_BOOTH) begin
                scan_idx = scan_idx - N_BOOTH;
            end
            if (!found && eligible[scan_idx[IdxW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = scan_idx[IdxW-1:0];
            end
        end
    end

    // busy_q blocks a grant in the ack/nack cycle, so vote pulses never abut
    assign grant      = (state_q == ST_OPEN) && !busy_q && found;
    assign gnt_choice = booth_choice[{gnt_idx, 1'b0} +: 2];

    always_comb begin
        ack_d    = '0;
        nack_d   = '0;
        vote_a_d = 1'b0;
        vote_b_d = 1'b0;
        vote_c_d = 1'b0;
        total_d  = total_q;
        start_d  = start_q;
        if (grant) begin
            start_d = (gnt_idx == IdxW'(N_BOOTH - 1)) ? '0 : gnt_idx + IdxW'(1);
            if (gnt_choice == 2'b00) begin
                nack_d[gnt_idx] = 1'b1;
            end else begin
                ack_d[gnt_idx] = 1'b1;
                vote_a_d = (gnt_choice == 2'b01);
                vote_b_d = (gnt_choice == 2'b10);
                vote_c_d = (gnt_choice == 2'b11);
                if (total_q != 16'hFFFF) begin
                    total_d = total_q + 16'd1;
                end
            end
        end
        // Once closing, every requester is refused once. A booth being answered
        // this cycle still holds req, so it is excluded until it drops.
        if ((state_q == ST_CLOSING) || (state_q == ST_CLOSED)) begin
            nack_d = booth_req & ~ack_q & ~nack_q;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_BOOTH; i++) begin
            if (grant && (gnt_idx == IdxW'(i))) begin
                cd_d[i] = CdLoad;
            end else if (cd_q[i] != 4'd0) begin
                cd_d[i] = cd_q[i] - 4'd1;
            end else begin
                cd_d[i] = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            tally_enable_q <= 1'b0;
            tally_admin_q  <= 1'b0;
            start_q        <= '0;
            busy_q         <= 1'b0;
            ack_q          <= '0;
            nack_q         <= '0;
            vote_a_q       <= 1'b0;
            vote_b_q       <= 1'b0;
            vote_c_q       <= 1'b0;
            total_q        <= '0;
            for (int unsigned i = 0; i < N_BOOTH; i++) begin
                cd_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            tally_enable_q <= (state_d == ST_OPEN) || (state_d == ST_CLOSING);
            tally_admin_q  <= (state_d == ST_CLOSED);
            start_q        <= start_d;
            busy_q         <= grant;
            ack_q          <= ack_d;
            nack_q         <= nack_d;
            vote_a_q       <= vote_a_d;
            vote_b_q       <= vote_b_d;
            vote_c_q       <= vote_c_d;
            total_q        <= total_d;
            cd_q           <= cd_d;
        end
    end

    assign booth_ack    = ack_q;
    assign booth_nack   = nack_q;
    assign tally_enable = tally_enable_q;
    assign tally_admin  = tally_admin_q;
    assign vote_A       = vote_a_q;
    assign vote_B       = vote_b_q;
    assign vote_C       = vote_c_q;
    assign votes_total  = total_q;
    assign poll_state   = state_q;

endmodule

// File: tb/tb_booth_arbiter.sv
// tb_booth_arbiter: scoreboard bench for booth_arbiter (4 booths, cooldown 4).
// The stimulus thread pushes expected ack/nack/vote events (with the cycle they
// must appear in) into a queue; a monitor pops and compares on every output event.
module tb_booth_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        open_poll;
    logic        close_poll;
    logic [3:0]  booth_req;
    logic [7:0]  booth_choice;
    logic [3:0]  booth_ack;
    logic [3:0]  booth_nack;
    logic        tally_enable;
    logic        tally_admin;
    logic        vote_A;
    logic        vote_B;
    logic        vote_C;
    logic [15:0] votes_total;
    logic [1:0]  poll_state;

    booth_arbiter #(
        .N_BOOTH  (4),
        .COOLDOWN (4)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .open_poll    (open_poll),
        .close_poll   (close_poll),
        .booth_req    (booth_req),
        .booth_choice (booth_choice),
        .booth_ack    (booth_ack),
        .booth_nack   (booth_nack),
        .tally_enable (tally_enable),
        .tally_admin  (tally_admin),
        .vote_A       (vote_A),
        .vote_B       (vote_B),
        .vote_C       (vote_C),
        .votes_total  (votes_total),
        .poll_state   (poll_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [3:0]  ack;
        logic [3:0]  nack;
        logic [2:0]  vote;   // {A,B,C}
        logic [15:0] total;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   c;

    localparam logic [2:0] VA = 3'b100;
    localparam logic [2:0] VB = 3'b010;
    localparam logic [2:0] VC = 3'b001;
    localparam logic [2:0] VN = 3'b000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int at, input logic [3:0] ack, input logic [3:0] nack,
                        input logic [2:0] vote, input logic [15:0] total);
        exp_t e;
        e.at = at; e.ack = ack; e.nack = nack; e.vote = vote; e.total = total;
        exp_q.push_back(e);
    endtask

    // Advance one cycle; a booth drops req the cycle after its ack/nack
    task automatic step();
        logic [3:0] done;
        done = booth_ack | booth_nack;
        @(posedge clk);
        #1;
        booth_req = booth_req & ~done;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic drive_req(input int i, input logic [1:0] ch);
        booth_req[i] = 1'b1;
        booth_choice[2*i +: 2] = ch;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        open_poll = 1'b0;
        close_poll = 1'b0;
        booth_req = '0;
        booth_choice = '0;
        #1;
        step();
        step();
        booth_req = '0;
        rst_n = 1'b1;
    endtask

    // Monitor: every output event must match the head of the queue
    always @(negedge clk) begin
        if ((|booth_ack) || (|booth_nack) || vote_A || vote_B || vote_C) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_output: got ack=%b nack=%b vote=%b%b%b, expected none (cycle %0d)",
                         booth_ack, booth_nack, vote_A, vote_B, vote_C, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_cycle", cyc, mon_e.at);
                chk("event_ack", {28'd0, booth_ack}, {28'd0, mon_e.ack});
                chk("event_nack", {28'd0, booth_nack}, {28'd0, mon_e.nack});
                chk("event_vote", {29'd0, vote_A, vote_B, vote_C}, {29'd0, mon_e.vote});
                chk("event_total", {16'd0, votes_total}, {16'd0, mon_e.total});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        open_poll = 1'b0;
        close_poll = 1'b0;
        booth_req = '0;
        booth_choice = '0;
        #1;
        step();
        step();
        chk("rst_state", poll_state, 2'b00);
        chk("rst_enable", tally_enable, 1'b0);
        chk("rst_admin", tally_admin, 1'b0);
        chk("rst_total", votes_total, 16'd0);
        chk("rst_ack_nack", {booth_ack, booth_nack}, 8'd0);
        rst_n = 1'b1;

        // Single booth vote: open at c, grant at c+1, ack + vote_A at c+2
        do_reset();
        c = cyc;
        open_poll = 1'b1;
        drive_req(0, 2'b01);
        push(c + 2, 4'b0001, 4'b0000, VA, 16'd1);
        step();
        open_poll = 1'b0;
        chk("t1_state_open", poll_state, 2'b01);
        chk("t1_enable", tally_enable, 1'b1);
        chk("t1_admin", tally_admin, 1'b0);
        step_to(c + 6);
        chk("t1_total", votes_total, 16'd1);

        // Four booths at once: acks 0,1,2,3 every second cycle, votes A,B,C,A
        do_reset();
        c = cyc;
        open_poll = 1'b1;
        drive_req(0, 2'b01);
        drive_req(1, 2'b10);
        drive_req(2, 2'b11);
        drive_req(3, 2'b01);
        push(c + 2, 4'b0001, 4'b0000, VA, 16'd1);
        push(c + 4, 4'b0010, 4'b0000, VB, 16'd2);
        push(c + 6, 4'b0100, 4'b0000, VC, 16'd3);
        push(c + 8, 4'b1000, 4'b0000, VA, 16'd4);
        step();
        open_poll = 1'b0;
        step_to(c + 11);
        chk("t2_total", votes_total, 16'd4);

        // Cooldown: booth1 re-requests at c+3, blocked until c+6; booth2 served at c+3.
        // Then booths 0 and 3 together with pointer at 2: booth3 first.
        do_reset();
        c = cyc;
        open_poll = 1'b1;
        drive_req(1, 2'b10);
        push(c + 2, 4'b0010, 4'b0000, VB, 16'd1);
        step();
        open_poll = 1'b0;
        step_to(c + 3);
        drive_req(1, 2'b11);
        drive_req(2, 2'b01);
        push(c + 4, 4'b0100, 4'b0000, VA, 16'd2);
        push(c + 7, 4'b0010, 4'b0000, VC, 16'd3);
        step_to(c + 9);
        drive_req(0, 2'b01);
        drive_req(3, 2'b10);
        push(c + 10, 4'b1000, 4'b0000, VB, 16'd4);
        push(c + 12, 4'b0001, 4'b0000, VA, 16'd5);
        step_to(c + 14);
        chk("t3_total", votes_total, 16'd5);

        // Invalid choice: nack only; later choice 11 accepted as C after cooldown
        do_reset();
        c = cyc;
        open_poll = 1'b1;
        drive_req(0, 2'b00);
        push(c + 2, 4'b0000, 4'b0001, VN, 16'd0);
        step();
        open_poll = 1'b0;
        step_to(c + 3);
        chk("t4_total_after_nack", votes_total, 16'd0);
        drive_req(0, 2'b11);
        drive_req(3, 2'b01);
        push(c + 4, 4'b1000, 4'b0000, VA, 16'd1);
        push(c + 7, 4'b0001, 4'b0000, VC, 16'd2);
        step_to(c + 9);
        chk("t4_total", votes_total, 16'd2);

        // Close while booth1 is granted: its vote completes, 2 and 3 get nack
        do_reset();
        c = cyc;
        open_poll = 1'b1;
        drive_req(1, 2'b10);
        drive_req(2, 2'b01);
        drive_req(3, 2'b11);
        push(c + 2, 4'b0010, 4'b0000, VB, 16'd1);
        push(c + 3, 4'b0000, 4'b1100, VN, 16'd1);
        step();
        open_poll = 1'b0;
        close_poll = 1'b1;
        chk("t5_state_open", poll_state, 2'b01);
        step();
        close_poll = 1'b0;
        chk("t5_state_closing", poll_state, 2'b10);
        chk("t5_enable_closing", tally_enable, 1'b1);
        chk("t5_admin_closing", tally_admin, 1'b0);
        step();
        chk("t5_state_closed", poll_state, 2'b11);
        chk("t5_admin_closed", tally_admin, 1'b1);
        chk("t5_enable_closed", tally_enable, 1'b0);
        step_to(c + 5);
        open_poll = 1'b1;
        drive_req(0, 2'b01);
        push(c + 6, 4'b0000, 4'b0001, VN, 16'd1);
        step();
        open_poll = 1'b0;
        chk("t5_closed_terminal", poll_state, 2'b11);
        step_to(c + 9);
        chk("t5_total", votes_total, 16'd1);

        // Reset during a grant cycle: immediate clear, no vote pulse follows
        do_reset();
        c = cyc;
        open_poll = 1'b1;
        drive_req(0, 2'b01);
        step();
        open_poll = 1'b0;
        chk("t6_state_open", poll_state, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_state", poll_state, 2'b00);
        chk("t6_async_enable", tally_enable, 1'b0);
        step();
        chk("t6_no_ack", {booth_ack, booth_nack}, 8'd0);
        chk("t6_no_vote", {vote_A, vote_B, vote_C}, 3'b000);
        booth_req = '0;
        rst_n = 1'b1;

        // Reset while an ack is showing clears it at once
        c = cyc;
        open_poll = 1'b1;
        drive_req(0, 2'b10);
        step();
        open_poll = 1'b0;
        step_to(c + 2);
        chk("t6_ack_before_reset", booth_ack, 4'b0001);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_ack_cleared", {booth_ack, vote_B}, 5'd0);
        chk("t6_total_cleared", votes_total, 16'd0);
        step();
        booth_req = '0;
        rst_n = 1'b1;

        // close_poll ignored in IDLE; open+close together in OPEN -> CLOSING
        close_poll = 1'b1;
        step();
        close_poll = 1'b0;
        chk("t6_close_in_idle", poll_state, 2'b00);
        open_poll = 1'b1;
        step();
        chk("t6_open", poll_state, 2'b01);
        close_poll = 1'b1;
        step();
        open_poll = 1'b0;
        close_poll = 1'b0;
        chk("t6_both_closing", poll_state, 2'b10);
        step();
        chk("t6_both_closed", poll_state, 2'b11);
        chk("t6_admin", tally_admin, 1'b1);

        step();
        step();
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
